sccb_master_param: RTL and testbench
====================================

// Module: sccb_master_param
// PURPOSE
//  Parametrised SCCB (OV-camera serial bus) master; self-timed from clk, no external mid_pulse strobe.
//  Runs 3-phase writes (ID+W, sub-address, data) and 2-phase-write + 2-phase-read reads
//  (ID+W, sub-address, stop, gap, ID+R, data, NA). Sub-address is 8 or 16 bit.
//  Optional check of slave don't-care/ACK bits. Sits between the camera-config sequencer
//  (start/busy/done handshake) and the SIOC/SIOD pads.
// PARAMETERS
//  CLK_DIV   4    clk cycles per SIOC quarter-period (>=2); one bit period = 4*CLK_DIV clk
//  SUB_W     8    sub-address width: 8 or 16 (16 sent MSB byte first)
//  BUS_WAIT  30   bit periods of bus-idle gap after every stop condition
//  ACK_CHECK 0    1: sample each don't-care bit, flag ack_err if slave leaves it high
// PORTS
//  clk       in  1      system clock
//  resetn    in  1      synchronous, active-low reset
//  start     in  1      request; sampled only while busy=0
//  rw        in  1      0 = write, 1 = read
//  id_addr   in  7      7-bit slave ID
//  sub_addr  in  SUB_W  register address
//  wdata     in  8      write data
//  rdata     out 8      read data; valid from done pulse until next accepted start
//  busy      out 1      transaction or post-stop gap in progress
//  done      out 1      one-clk pulse at end of final stop condition
//  ack_err   out 1      sticky per transaction, cleared on accept; always 0 if ACK_CHECK=0
//  sioc      out 1      SCCB clock
//  siod_i    in  1      SIOD pad input
//  siod_o    out 1      SIOD drive value
//  siod_oe   out 1      1 = master drives SIOD
//  pwdn      out 1      tied 0
// BEHAVIOUR
//  Reset (resetn=0 at posedge clk): sioc=1, siod_o=1, siod_oe=1, busy=0, done=0, rdata=0, ack_err=0,
//   state IDLE, counters 0. Reset mid-transaction aborts at once; no stop generated.
//  Accept: IDLE & start=1 -> latch rw/id_addr/sub_addr/wdata, busy=1 next clk. start while busy ignored.
//  Bit timing: quarter counter wraps at CLK_DIV-1. Data bit: Q0,Q1 sioc=0 (siod changes at Q0 entry);
//   Q2,Q3 sioc=1; slave data sampled at end of Q2.
//  START: siod 1->0 at Q2 while sioc=1. STOP: siod 0 during Q0-Q1, 1->0->1 rise at Q2 while sioc=1.
//  Bytes MSB first, 9 bit periods each; 9th bit: siod_oe=0 (DC/ACK), or master drives NA=1 after read byte.
//  Read bits: siod_oe=0; rdata[7-k] <= siod_i sampled at end of Q2.
//  FSM: IDLE -> START -> TX_ID -> TX_SUB (SUB_W/8 bytes) -> {rw=0: TX_DATA -> STOP -> GAP -> IDLE}
//   {rw=1: STOP -> GAP -> START -> TX_ID(R) -> RX_DATA -> NA -> STOP -> GAP -> IDLE}.
//  done pulses on clk after last quarter of final STOP; busy stays 1 through final GAP (BUS_WAIT bit periods).
//  Idle bus: sioc=1, siod_o=1, siod_oe=1. Between transactions sioc never glitches.
//  Bit counter 4 bits, gap counter $clog2(BUS_WAIT+1) bits, quarter counter $clog2(CLK_DIV) bits.
// STRUCTURE
//  Package sccb_pkg: FSM state enum, SUB_W legality check, phase/bit-period constants.
//  Sub-module sccb_qtick_gen: CLK_DIV divider emitting quarter index 0..3 and end-of-quarter strobe.
//  Single shift register (9 bit) shared by TX and RX bytes.
// TESTING (CLK_DIV=2, bit period 8 clk, BUS_WAIT=2, slave BFM on siod)
//  Write id=0x21 sub=0x12 wd=0x80: bus shows S,0x42,DC,0x12,DC,0x80,DC,P; done at 29*8 clk after busy rises.
//  Read id=0x21 sub=0x0A, BFM returns 0xA5: S,0x42,DC,0x0A,DC,P,gap,S,0x43,DC,0xA5,NA=1,P; rdata=0xA5.
//  SUB_W=16 write sub=0x3008 wd=0x82: bytes 0x30 then 0x08; 38 bit periods to done.
//  ACK_CHECK=1, BFM leaves SIOD high on 2nd DC: ack_err=1 at done; cleared at next accept.
//  start pulsed while busy, and held high across done: only one transaction per accept, gap respected.
//  resetn=0 mid TX_SUB: next clk sioc=1, siod_o=1, siod_oe=1, busy=0; new write completes normally.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM states, bit-period constants and sub-address width helpers for the SCCB master.
package sccb_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TX_ID, S_TX_SUB, S_TX_DATA, S_RX_DATA, S_NA, S_STOP, S_GAP
  } state_t;
  localparam int QUARTERS = 4;
  localparam logic [3:0] LAST_BIT = 4'd8;
  localparam logic [3:0] LAST_RX_BIT = 4'd7;
  function automatic bit sub_w_legal(input int w);
    return w == 8 || w == 16;
  endfunction
  function automatic int sub_bytes(input int w);
    return sub_w_legal(w) ? w / 8 : 1;
  endfunction
endpackage

// File: rtl/sccb_qtick_gen.sv
// sccb_qtick_gen: divides clk into SIOC quarter periods; held at quarter 0 while disabled.
module sccb_qtick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_en,
  output logic [1:0] o_q,
  output logic       o_qend
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] r_cnt;
  logic [1:0] r_q;
  assign o_qend = i_en && r_cnt == CW'(CLK_DIV - 1);
  assign o_q = r_q;
  always_ff @(posedge clk) begin
    if (!resetn || !i_en) begin
      r_cnt <= '0;
      r_q <= '0;
    end else if (o_qend) begin
      r_cnt <= '0;
      r_q <= r_q + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sccb_master_param.sv
// sccb_master_param: self-timed SCCB master running 3-phase writes and 2+2-phase reads.
module sccb_master_param
  import sccb_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SUB_W     = 8,
  parameter int BUS_WAIT  = 30,
  parameter int ACK_CHECK = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       id_addr,
  input  logic [SUB_W-1:0] sub_addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             sioc,
  input  logic             siod_i,
  output logic             siod_o,
  output logic             siod_oe,
  output logic             pwdn
);
  localparam int NB = sub_bytes(SUB_W);
  localparam int GW = (BUS_WAIT < 1) ? 1 : $clog2(BUS_WAIT + 1);
  state_t r_state, w_next;
  logic [1:0] w_q;
  logic w_qend, w_bit_end, w_samp, w_byte_end, w_last_sub, w_tx, w_ld, w_final;
  logic [7:0] w_ld_byte;
  logic [3:0] r_bit;
  logic [GW-1:0] r_gap;
  logic r_byte, r_rw, r_rd, r_done, r_ack;
  logic [6:0] r_id;
  logic [SUB_W-1:0] r_sub;
  logic [7:0] r_wd, r_rdata;
  logic [8:0] r_sr;

  sccb_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .resetn(resetn),
    .i_en  (r_state != S_IDLE),
    .o_q   (w_q),
    .o_qend(w_qend)
  );

  assign w_bit_end = w_qend && w_q == 2'd3;
  assign w_samp = w_qend && w_q == 2'd2;
  assign w_byte_end = w_bit_end && r_bit == LAST_BIT;
  assign w_last_sub = r_byte == 1'(NB - 1);
  assign w_tx = r_state inside {S_TX_ID, S_TX_SUB, S_TX_DATA};
  // Only the second pass of a read (or any write) ends the transaction.
  assign w_final = !r_rw || r_rd;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign ack_err = r_ack;
  assign rdata = r_rdata;
  assign pwdn = 1'b0;

  always_comb begin
    w_next = r_state;
    sioc = 1'b1;
    siod_o = 1'b1;
    siod_oe = 1'b1;
    case (r_state)
      S_IDLE: w_next = start ? S_START : S_IDLE;
      S_START: begin
        siod_o = ~w_q[1];
        if (w_bit_end) w_next = S_TX_ID;
      end
      S_TX_ID, S_TX_SUB, S_TX_DATA: begin
        sioc = w_q[1];
        siod_o = r_sr[8];
        siod_oe = r_bit != LAST_BIT;
        if (w_byte_end && r_state == S_TX_ID) w_next = r_rd ? S_RX_DATA : S_TX_SUB;
        if (w_byte_end && r_state == S_TX_SUB && w_last_sub) w_next = r_rw ? S_STOP : S_TX_DATA;
        if (w_byte_end && r_state == S_TX_DATA) w_next = S_STOP;
      end
      S_RX_DATA: begin
        sioc = w_q[1];
        siod_oe = 1'b0;
        if (w_bit_end && r_bit == LAST_RX_BIT) w_next = S_NA;
      end
      S_NA: begin
        sioc = w_q[1];
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        sioc = w_q != 2'd0;
        siod_o = w_q[1];
        if (w_bit_end) w_next = S_GAP;
      end
      S_GAP: if (w_bit_end && r_gap == GW'(BUS_WAIT - 1)) w_next = (r_rw && !r_rd) ? S_START : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_ld = w_bit_end && (w_next inside {S_TX_ID, S_TX_SUB, S_TX_DATA}) && (w_next != r_state || r_bit == LAST_BIT);
    w_ld_byte = w_next == S_TX_ID ? {r_id, r_rd} :
                w_next == S_TX_DATA ? r_wd :
                r_state == S_TX_SUB ? r_sub[7:0] : r_sub[SUB_W-1 -: 8];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_bit <= '0;
      r_gap <= '0;
      r_byte <= 1'b0;
      r_rw <= 1'b0;
      r_rd <= 1'b0;
      r_id <= '0;
      r_sub <= '0;
      r_wd <= '0;
      r_sr <= '0;
      r_done <= 1'b0;
      r_ack <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == S_STOP && w_bit_end && w_final;
      r_bit <= (w_next != r_state) ? 4'd0 : !w_bit_end ? r_bit : (r_bit == LAST_BIT) ? 4'd0 : r_bit + 4'd1;
      r_gap <= (w_next != r_state) ? '0 : (r_state == S_GAP && w_bit_end) ? r_gap + GW'(1) : r_gap;
      if (r_state == S_IDLE && start) begin
        r_rw <= rw;
        r_id <= id_addr;
        r_sub <= sub_addr;
        r_wd <= wdata;
        r_rd <= 1'b0;
        r_ack <= 1'b0;
      end
      if (r_state == S_GAP && w_next == S_START) r_rd <= 1'b1;
      if (w_ld && w_next == S_TX_SUB) r_byte <= r_state == S_TX_SUB;
      // One shift register serves both directions: RX samples in at Q2, TX shifts out per bit.
      if (r_state == S_RX_DATA && w_samp) r_sr <= {r_sr[7:0], siod_i};
      else if (w_ld) r_sr <= {w_ld_byte, 1'b1};
      else if (w_tx && w_bit_end) r_sr <= {r_sr[7:0], 1'b1};
      if (ACK_CHECK != 0 && w_tx && w_samp && r_bit == LAST_BIT && siod_i) r_ack <= 1'b1;
      if (r_state == S_STOP && w_bit_end && w_final && r_rw) r_rdata <= r_sr[7:0];
    end
  end
endmodule

// File: tb/tb_sccb_master_param.sv
// tb_sccb_master_param: table-driven check of the SCCB master with a pin-level slave model and bus decoder.
module tb_sccb_master_param;
  typedef struct {
    logic rw; logic [6:0] id; logic [15:0] sub; logic [7:0] wd; logic [7:0] bfm;
    int nak; logic [7:0] rd; logic ack; int tdone; int tbusy;
  } vec_t;

  logic clk = 1'b0, resetn = 1'b0, st8 = 1'b0, st16 = 1'b0, rw = 1'b0, sel = 1'b0;
  logic [6:0] id = '0;
  logic [15:0] sub = '0;
  logic [7:0] wd = '0, bfm_rd = '0;
  int nak_at = -1;
  logic [7:0] rd8, rd16, rd_m;
  logic busy8, done8, ack8, c8, o8, oe8, pw8;
  logic busy16, done16, ack16, c16, o16, oe16, pw16;
  logic bus_c, bus_o, bus_oe, bus_d, bfm_d, busy_m, done_m, ack_m;
  int mon_q[$], exp_q[$];
  int fk = 0, ncmp = 0, nfail = 0;
  logic p_c = 1'b1, p_d = 1'b1, rdf = 1'b0;
  int fc = -1;

  always #5 clk = ~clk;

  sccb_master_param #(.CLK_DIV(2), .SUB_W(8), .BUS_WAIT(2), .ACK_CHECK(1)) dut (
    .clk(clk), .resetn(resetn), .start(st8), .rw(rw), .id_addr(id), .sub_addr(sub[7:0]),
    .wdata(wd), .rdata(rd8), .busy(busy8), .done(done8), .ack_err(ack8), .sioc(c8),
    .siod_i(bus_d), .siod_o(o8), .siod_oe(oe8), .pwdn(pw8));

  sccb_master_param #(.CLK_DIV(2), .SUB_W(16), .BUS_WAIT(2), .ACK_CHECK(0)) d16 (
    .clk(clk), .resetn(resetn), .start(st16), .rw(rw), .id_addr(id), .sub_addr(sub),
    .wdata(wd), .rdata(rd16), .busy(busy16), .done(done16), .ack_err(ack16), .sioc(c16),
    .siod_i(bus_d), .siod_o(o16), .siod_oe(oe16), .pwdn(pw16));

  assign bus_c = sel ? c16 : c8;
  assign bus_o = sel ? o16 : o8;
  assign bus_oe = sel ? oe16 : oe8;
  assign busy_m = sel ? busy16 : busy8;
  assign done_m = sel ? done16 : done8;
  assign ack_m = sel ? ack16 : ack8;
  assign rd_m = sel ? rd16 : rd8;
  // Slave: read-data bits at frame indices 9..16 of a read frame, else ACK low unless told to NAK.
  assign bfm_d = (rdf && fc >= 9 && fc <= 16) ? bfm_rd[3'(16 - fc)] : (fc == nak_at);
  assign bus_d = bus_oe ? bus_o : bfm_d;

  // Bus decoder on settled pin values: -1 start, -2 stop, 0/1 bit captured at SIOC rise.
  always @(negedge clk) begin
    if (p_c && bus_c && p_d && !bus_d) begin
      mon_q.push_back(-1);
      fc <= -1;
      rdf <= 1'b0;
    end else if (p_c && bus_c && !p_d && bus_d) begin
      mon_q.push_back(-2);
    end else if (!p_c && bus_c) begin
      mon_q.push_back(int'(bus_d));
      if (fc == 7) rdf <= bus_d;
    end else if (p_c && !bus_c) begin
      fc <= fc + 1;
    end
    p_c <= bus_c;
    p_d <= bus_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic es();
    exp_q.push_back(-1);
    fk = 0;
  endtask

  task automatic eb(input logic [7:0] b, input int nak, input logic na);
    for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
    exp_q.push_back(na ? 1 : int'(fk + 8 == nak));
    fk += 9;
  endtask

  task automatic ep();
    exp_q.push_back(0);
    exp_q.push_back(-2);
  endtask

  task automatic build(input logic s, input vec_t v);
    exp_q.delete();
    es();
    eb({v.id, 1'b0}, v.nak, 1'b0);
    if (s) eb(v.sub[15:8], v.nak, 1'b0);
    eb(v.sub[7:0], v.nak, 1'b0);
    if (!v.rw) eb(v.wd, v.nak, 1'b0);
    else begin
      ep();
      es();
      eb({v.id, 1'b1}, v.nak, 1'b0);
      eb(v.bfm, -1, 1'b1);
    end
    ep();
  endtask

  task automatic do_txn(input logic s, input vec_t v, input bit hold, input int pulse);
    int n, nd, dn, bad;
    sel = s;
    bfm_rd = v.bfm;
    nak_at = v.nak;
    build(s, v);
    @(posedge clk); #1;
    mon_q.delete();
    rw = v.rw; id = v.id; sub = v.sub; wd = v.wd;
    st8 = !s; st16 = s;
    @(posedge clk); #1;
    if (!hold) begin st8 = 1'b0; st16 = 1'b0; end
    chk("busy after accept", busy_m, 1);
    chk("ack_err cleared on accept", ack_m, 0);
    n = 0; nd = 0; dn = -1;
    while (busy_m && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (done_m) begin nd++; if (dn < 0) dn = n; end
      if (!hold) begin st8 = !s && n == pulse; st16 = s && n == pulse; end
    end
    chk("cycles to done", dn, v.tdone);
    chk("done pulse count", nd, 1);
    chk("busy cycles", n, v.tbusy);
    chk("rdata", rd_m, v.rd);
    chk("ack_err", ack_m, v.ack);
    chk("bus symbol count", mon_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      if (bad < 0 && mon_q[i] != exp_q[i]) bad = i;
    chk("bus first wrong symbol index", bad, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[5];
    vec_t vp;
    int n;
    logic b;
    tv[0] = '{1'b0, 7'h21, 16'h0012, 8'h80, 8'h00, -1, 8'h00, 1'b0, 232, 248};
    tv[1] = '{1'b1, 7'h21, 16'h000A, 8'h00, 8'hA5, -1, 8'hA5, 1'b0, 336, 352};
    tv[2] = '{1'b0, 7'h3C, 16'h00FF, 8'h5A, 8'h00, 17, 8'hA5, 1'b1, 232, 248};
    tv[3] = '{1'b0, 7'h7F, 16'h0000, 8'hFF, 8'h00, -1, 8'hA5, 1'b0, 232, 248};
    tv[4] = '{1'b1, 7'h00, 16'h0080, 8'h00, 8'h3C, -1, 8'h3C, 1'b0, 336, 352};
    repeat (3) @(posedge clk);
    #1;
    chk("reset pins", {c8, o8, oe8, busy8, done8, ack8, pw8}, 7'b1110000);
    chk("reset rdata", rd8, 0);
    chk("reset pins 16-bit", {c16, o16, oe16, busy16, done16, ack16, pw16}, 7'b1110000);
    resetn = 1'b1;
    foreach (tv[i]) do_txn(1'b0, tv[i], 1'b0, -1);
    vp = '{1'b0, 7'h21, 16'h3008, 8'h82, 8'h00, 17, 8'h00, 1'b0, 304, 320};
    do_txn(1'b1, vp, 1'b0, -1);
    vp = tv[0];
    vp.rd = 8'h3C;
    do_txn(1'b0, vp, 1'b0, 240);
    b = 1'b0;
    repeat (20) begin @(posedge clk); #1; b |= busy8; end
    chk("no accept from start pulsed while busy", b, 0);
    do_txn(1'b0, vp, 1'b1, -1);
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("re-accept after held start", busy8, 1);
    n = 0;
    while (busy8 && n < 4000) begin @(posedge clk); #1; n++; end
    chk("held start second busy cycles", n, 248);
    @(posedge clk); #1;
    rw = 1'b0; id = 7'h55; sub = 16'h0033; wd = 8'h11;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (104) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("reset mid sub-address pins", {c8, o8, oe8, busy8, done8}, 5'b11100);
    resetn = 1'b1;
    vp = tv[3];
    vp.rd = 8'h00;
    do_txn(1'b0, vp, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
